imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//   Shares the single-port instruction memory between two requesters: port 0
//   (CPU instruction fetch) and port 1 (loader/debug, read or write).
//   Fixed priority to port 0, with a starvation counter that forces a port-1 grant.
//   Also supports a hold that parks the CPU during program load.
//   Sits between the core/loader and the word-addressed imem array.
//   Returns registered responses one cycle after acceptance.
// PARAMETERS
//   ADDR_WORDS  8192  number of 32-bit words implemented; word index >= this is out of range
//   MAX_WAIT    4     port-1 denied cycles before forced grant; legal range 1..255
// PORTS
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   hold_cpu   in   1   1 = port 0 never granted (loader mode)
//   p0_valid   in   1   port-0 fetch request
//   p0_ready   out  1   port-0 request accepted this cycle (combinational)
//   p0_addr    in   32  port-0 byte address
//   p0_rvalid  out  1   port-0 response strobe, 1 cycle
//   p0_rdata   out  32  port-0 read data, valid with p0_rvalid
//   p0_err     out  1   port-0 error (misaligned/out of range), valid with p0_rvalid
//   p1_valid   in   1   port-1 request
//   p1_ready   out  1   port-1 request accepted this cycle (combinational)
//   p1_addr    in   32  port-1 byte address
//   p1_we      in   1   1 = write p1_wdata, 0 = read
//   p1_wdata   in   32  port-1 write data
//   p1_rvalid  out  1   port-1 response strobe, 1 cycle
//   p1_rdata   out  32  port-1 read data (0 for writes and errors)
//   p1_err     out  1   port-1 error, valid with p1_rvalid
//   mem_addr   out  32  byte address to imem, {word_idx,2'b00}
//   mem_rdata  in   32  imem combinational read data
//   mem_we     out  1   imem write enable
//   mem_wdata  out  32  imem write data
// BEHAVIOUR
//   Reset (async, rst_n=0): all *_rvalid, *_rdata, *_err = 0; wait_cnt = 0.
//     A response pending at reset is dropped, never emitted.
//   Grant (combinational, one request per cycle):
//     force1 = p1_valid & (wait_cnt == MAX_WAIT)
//     g0 = p0_valid & ~hold_cpu & ~force1
//     g1 = p1_valid & ~g0
//     p0_ready = g0; p1_ready = g1.
//     Accept = valid & ready; a requester holds addr/we/wdata until it is accepted.
//   Memory drive, in the accept cycle only:
//     mem_addr = granted addr with [1:0] forced to 00.
//     With no grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
//     mem_we = g1 & p1_we & ~bad.
//     bad = (addr[1:0] != 0) | (addr[31:2] >= ADDR_WORDS).
//     A bad request never writes memory.
//   Response, registered on the accept edge and presented the next cycle:
//     The accepted port's rvalid is 1 for exactly one cycle.
//     rdata = mem_rdata sampled at the accept edge for good reads; 0 for writes and bad requests.
//     err = bad.
//     The other port's rvalid = 0 and its rdata/err hold their previous values.
//   Throughput: back-to-back accepts are allowed every cycle; no response backpressure.
//   Starvation counter wait_cnt (8 bit):
//     Cleared when p1 is accepted or when p1_valid = 0.
//     Otherwise +1 per cycle, saturating at MAX_WAIT.
//   Boundaries:
//     hold_cpu = 1: p1 is granted whenever valid; counter stays 0.
//     Both valid with force1: p1 wins; p0 is granted the following cycle if still valid.
//     Write then read of the same word on consecutive cycles: the read returns the new data,
//       because memory is written at the accept edge.
// TESTING
//   1 Reset: rst_n=0 mid-accept -> next cycle p0_rvalid=p1_rvalid=0, rdata=0, err=0.
//   2 p0 read 0x0000_0010, mem holds 0xDEAD_BEEF at word 4
//       -> p0_ready=1, mem_addr=0x10, next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p0_err=0.
//   3 p0 and p1 valid continuously, MAX_WAIT=4
//       -> p0 granted 4 cycles, p1 granted on 5th, p0 again on 6th.
//   4 p1 write 0x1234_5678 to 0x20, then p1 read 0x20
//       -> mem_we=1 one cycle; read response rdata=0x12345678.
//   5 p0 read 0x0000_0006 -> mem_we=0, p0_err=1, p0_rdata=0.
//     p1 write to 0x0000_8000 (word 8192) -> p1_err=1, no mem_we.
//   6 hold_cpu=1 with p0_valid=1 -> p0_ready stays 0.
//     p1 reads are served every cycle; release hold -> p0 granted.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port instruction memory between the
// CPU fetch port (p0) and the loader/debug port (p1). Port 0 has fixed
// priority, but port 1 is forced through after MAX_WAIT denied cycles.
// hold_cpu parks the CPU while a program is loaded. Responses are
// registered on the accept edge and presented the following cycle.
module imem_port_arbiter #(
  parameter int unsigned ADDR_WORDS = 8192,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_cpu,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic        p1_we,
  input  logic [31:0] p1_wdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  logic [7:0]  wait_cnt;
  logic        force1, g0, g1, bad;
  logic [31:0] sel_addr, rd_word;

  // Grant: p0 wins unless parked or p1 has waited its full budget.
  always_comb begin
    force1 = p1_valid & (wait_cnt == 8'(MAX_WAIT));
    g0     = p0_valid & ~hold_cpu & ~force1;
    g1     = p1_valid & ~g0;
  end

  assign p0_ready = g0;
  assign p1_ready = g1;

  // Memory drive and error decode for the granted request only.
  always_comb begin
    sel_addr  = g0 ? p0_addr : p1_addr;
    bad       = (sel_addr[1:0] != 2'b00) |
                ({2'b00, sel_addr[31:2]} >= 32'(ADDR_WORDS));
    mem_addr  = (g0 | g1) ? {sel_addr[31:2], 2'b00} : 32'h0;
    mem_we    = g1 & p1_we & ~bad;
    mem_wdata = g1 ? p1_wdata : 32'h0;
    // Writes and bad requests return zero data.
    rd_word   = (bad | (g1 & p1_we)) ? 32'h0 : mem_rdata;
  end

  // Starvation counter: counts cycles p1 is valid but not accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= 8'h0;
    else if (!p1_valid || g1)   wait_cnt <= 8'h0;
    else if (wait_cnt != 8'(MAX_WAIT)) wait_cnt <= wait_cnt + 8'h1;
  end

  // Response registers: only the accepted port updates its data/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= 32'h0;
      p0_err    <= 1'b0;
      p1_rvalid <= 1'b0;
      p1_rdata  <= 32'h0;
      p1_err    <= 1'b0;
    end else begin
      p0_rvalid <= g0;
      p1_rvalid <= g1;
      if (g0) begin
        p0_rdata <= rd_word;
        p0_err   <= bad;
      end
      if (g1) begin
        p1_rdata <= rd_word;
        p1_err   <= bad;
      end
    end
  end

endmodule
